wave_player: RTL and testbench
==============================

# wave_player

Playback sequencer that sits directly downstream of the dacboard sample `memory`. It reads a contiguous address window of stored samples through the memory's registered read port and presents them to the DAC output register at a programmable sample rate, one sample per period. It runs one-shot or looping, under start/stop control from the host-side control logic.

## Interface
Parameters:
- `BITS`, 8: sample width; must match the memory's `BITS`.
- `SIZE`, 128: memory depth in words; `AW = $clog2(SIZE)` is the address width.
- `DIV_BITS`, 16: width of the sample-period divider.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle start request.
- `stop`  in  1  single-cycle abort request.
- `cfg_start_addr`  in  AW  first sample address; latched on accepted start.
- `cfg_end_addr`  in  AW  last sample address, inclusive; latched on accepted start.
- `cfg_div`  in  DIV_BITS  sample period minus one, in clocks; latched on accepted start.
- `rd_en`  out  1  memory read enable, registered.
- `rd_addr`  out  AW  memory read address, registered.
- `rd_data`  in  BITS  memory `data_out`; valid in the cycle after `rd_en`.
- `dac_data`  out  BITS  current DAC sample; holds its value between strobes.
- `dac_strobe`  out  1  one-cycle pulse when `dac_data` updates.
- `busy`  out  1  high from the cycle after an accepted start until the return to IDLE.
- `done`  out  1  one-cycle pulse on natural completion (one-shot only).

## Operation
- States are IDLE, PRIME, WAIT, RUN.
- **IDLE**
  - `start` with `stop` low is accepted: latch the config, set `addr = cfg_start_addr`, go to PRIME.
  - `start` together with `stop` is ignored; stop wins.
- **PRIME**
  - Assert `rd_en` with `rd_addr = addr`, then go to WAIT.
- **WAIT**
  - Capture `rd_data` into the prefetch register.
  - Load the divider so the first strobe fires in the next cycle, then go to RUN.
- **RUN**
  - The divider counts down. When it reaches 0, that cycle is a tick; the divider reloads to the effective divisor.
  - On a tick:
    - `dac_data <= prefetch` and `dac_strobe` pulses.
    - If the strobed address ≠ `end_addr`: advance `addr` and issue `rd_en` for it in the same cycle. Capture `rd_data` into prefetch in the following cycle.
    - If the strobed address = `end_addr`: behaviour depends on the loop configuration (see Configuration).
- **Effective divisor** is `max(cfg_div, 1)`, so the sample period is at least 2 clocks. `cfg_div = 0` behaves exactly like `cfg_div = 1`.
- **Address increment**
  - `addr + 1`, wrapping from `SIZE-1` to 0; this holds for non-power-of-two `SIZE` too.
  - If `end < start`, the window wraps through 0.
  - If `start == end`, the window is a single sample.
- **`stop` while busy:** return to IDLE on the next edge.
  - No further strobes or reads.
  - `dac_data` holds its last value.
  - `done` is not pulsed.
- `start` while busy is ignored.
- Config inputs are sampled only on an accepted start. Changing them mid-run has no effect.

## Timing
- **Reset values:** `rd_en = 0`, `rd_addr = 0`, `dac_data = 0`, `dac_strobe = 0`, `busy = 0`, `done = 0`, state IDLE.
- **Reset mid-run** forces the reset values immediately (asynchronously). Nothing resumes after reset release.
- **Start sequence** (S = cycle in which `start` is sampled high):
  - S+1: `busy = 1`, `rd_en = 1`, `rd_addr = start`.
  - S+3: first `dac_strobe`, carrying `mem[start]`.
- **Sample rate:** subsequent strobes every `eff_div + 1` cycles.
- **Read port usage:** `rd_en` is asserted only in PRIME and in RUN tick cycles, so there is at most one read in flight. The prefetch is always valid before the next tick.
- **One-shot completion:** `done` pulses in the cycle after the last strobe and `busy` falls in the same cycle.

## Configuration
- Macro `WAVE_PLAYER_LOOP_EN`.
- **Defined:** on a tick that strobes `end_addr`, `addr` reloads `start_addr` and a read of it is issued. Playback repeats seamlessly with no gap in the strobe period, until `stop`. `done` never pulses.
- **Undefined:** on a tick that strobes `end_addr`, no read is issued. The FSM goes to IDLE on the next edge and pulses `done`. The loop logic is absent.

## Test plan
- **Reset:** assert `rst_n = 0` during RUN → all outputs 0 immediately. After release, no strobes until a new start.
- **One-shot:** mem[4..7] = 0x11, 0x22, 0x33, 0x44; start = 4, end = 7, div = 3 → strobes at S+3, S+7, S+11, S+15 with the values in order. `done` at S+16; `busy` low from S+16.
- **Wrap window:** SIZE = 100, start = 98, end = 1, div = 1 → addresses 98, 99, 0, 1 are strobed, every 2 cycles.
- **div = 0 and single sample:** div = 0, start = end = 5 → exactly one strobe, carrying `mem[5]`, at S+3.
- **Abort and contention:** `stop` between the 2nd and 3rd strobe → no 3rd strobe, `dac_data` holds the 2nd sample, no `done`. `start` and `stop` in the same IDLE cycle → `busy` stays 0.
- **Loop (`WAVE_PLAYER_LOOP_EN`):** start = 0, end = 2, div = 2 → strobe sequence `mem[0,1,2,0,1,2,…]`, uniformly spaced 3 cycles apart; `done` never asserted.

Source files
------------

// File: rtl/wave_player.sv
// wave_player: plays a contiguous window of samples from the dacboard sample
// memory into the DAC output register, one sample per programmable period.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   start, stop           single-cycle control requests (stop has priority)
//   cfg_start_addr        first sample address (latched on accepted start)
//   cfg_end_addr          last sample address, inclusive (latched on start)
//   cfg_div               sample period minus one, in clocks (latched on start)
//   rd_en, rd_addr        registered read request to the memory
//   rd_data               memory data, valid the cycle after rd_en
//   dac_data, dac_strobe  current DAC sample and its one-cycle update pulse
//   busy                  playback in progress
//   done                  one-cycle pulse on natural one-shot completion
//
// Build option: define WAVE_PLAYER_LOOP_EN to replay the window endlessly
// until stop; without it playback is one-shot and ends with a done pulse.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for an accepted start
// S_PRIME | first read of the window is on the memory port
// S_WAIT  | first sample arrives; it is strobed on the next edge
// S_RUN   | divider running, one strobe (and next read) per period

module wave_player #(
  parameter int BITS     = 8,
  parameter int SIZE     = 128,
  parameter int DIV_BITS = 16,
  localparam int AW      = $clog2(SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [AW-1:0]       cfg_start_addr,
  input  logic [AW-1:0]       cfg_end_addr,
  input  logic [DIV_BITS-1:0] cfg_div,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [BITS-1:0]     rd_data,
  output logic [BITS-1:0]     dac_data,
  output logic                dac_strobe,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_WAIT, S_RUN} state_e;

  state_e              state_q;
  logic [AW-1:0]       end_q;
  logic [AW-1:0]       addr_q;
  logic [DIV_BITS-1:0] div_q;
  logic [DIV_BITS-1:0] cnt_q;
  logic [BITS-1:0]     pf_q;
  logic                pf_vld_q;
  logic                last_q;
  logic                rd_en_q;
  logic [AW-1:0]       rd_addr_q;
  logic [BITS-1:0]     dac_q;
  logic                strobe_q;
  logic                busy_q;
  logic                done_q;
`ifdef WAVE_PLAYER_LOOP_EN
  logic [AW-1:0]       start_q;
`endif

  logic [AW-1:0]       addr_inc_d;
  logic [AW-1:0]       addr_d;
  logic                last_d;
  logic [BITS-1:0]     sample_d;
  logic [DIV_BITS-1:0] div_eff_d;

  always_comb begin
    addr_inc_d = (addr_q == AW'(SIZE - 1)) ? '0 : addr_q + 1'b1;
`ifdef WAVE_PLAYER_LOOP_EN
    addr_d = (addr_q == end_q) ? start_q : addr_inc_d;
    last_d = 1'b0;
`else
    addr_d = addr_inc_d;
    last_d = (addr_q == end_q);
`endif
    // A read issued on the previous tick lands on rd_data this cycle; use it
    // directly so a 2-clock period never waits on the prefetch register.
    sample_d  = pf_vld_q ? rd_data : pf_q;
    div_eff_d = (cfg_div == '0) ? DIV_BITS'(1) : cfg_div;
  end

  // Strobe/read outputs are registered one edge early: the "tick" the
  // divider reaches is the edge that makes dac_strobe and rd_en visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      end_q     <= '0;
      addr_q    <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      pf_q      <= '0;
      pf_vld_q  <= 1'b0;
      last_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      dac_q     <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef WAVE_PLAYER_LOOP_EN
      start_q   <= '0;
`endif
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      pf_vld_q <= rd_en_q;
      if (pf_vld_q) pf_q <= rd_data;

      if (stop && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start && !stop) begin
`ifdef WAVE_PLAYER_LOOP_EN
              start_q <= cfg_start_addr;
`endif
              end_q     <= cfg_end_addr;
              div_q     <= div_eff_d;
              addr_q    <= cfg_start_addr;
              rd_addr_q <= cfg_start_addr;
              rd_en_q   <= 1'b1;
              last_q    <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= S_PRIME;
            end
          end
          S_PRIME: state_q <= S_WAIT;
          default: begin
            if (state_q == S_RUN && last_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (state_q == S_WAIT || cnt_q == '0) begin
              state_q  <= S_RUN;
              dac_q    <= sample_d;
              strobe_q <= 1'b1;
              cnt_q    <= div_q;
              last_q   <= last_d;
              if (!last_d) begin
                addr_q    <= addr_d;
                rd_addr_q <= addr_d;
                rd_en_q   <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign dac_data   = dac_q;
  assign dac_strobe = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_wave_player.sv
module tb_wave_player;
  localparam int BITS     = 8;
  localparam int SIZE     = 100;
  localparam int DIV_BITS = 16;
  localparam int AW       = $clog2(SIZE);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic [AW-1:0]       cfg_start_addr = '0;
  logic [AW-1:0]       cfg_end_addr = '0;
  logic [DIV_BITS-1:0] cfg_div = '0;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [BITS-1:0]     rd_data = '0;
  logic [BITS-1:0]     dac_data;
  logic                dac_strobe;
  logic                busy;
  logic                done;

  wave_player #(.BITS(BITS), .SIZE(SIZE), .DIV_BITS(DIV_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
    .cfg_div(cfg_div), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .dac_data(dac_data), .dac_strobe(dac_strobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // sample memory with a registered read port
  logic [BITS-1:0] mem [2**AW];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observation log, sampled mid-cycle
  int st_cyc[$];
  int st_val[$];
  int done_cyc[$];
  int rd_cnt = 0;
  int fall_cyc = -1;
  bit busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dac_strobe) begin
        st_cyc.push_back(cyc);
        st_val.push_back(int'(dac_data));
      end
      if (done) done_cyc.push_back(cyc);
      if (rd_en) rd_cnt++;
      if (busy_prev && !busy) fall_cyc = cyc;
    end
    busy_prev = busy;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    st_cyc.delete();
    st_val.delete();
    done_cyc.delete();
    rd_cnt = 0;
    fall_cyc = -1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 2**AW; i++) mem[i] = BITS'($urandom);
  endtask

  // Reference: window of n samples (start..end, wrapping at SIZE), first
  // strobe 3 cycles after start, then one every max(div,1)+1 cycles.
  task automatic play(input int sa, input int ea, input int dv);
    int n, per, want, s, t;
    n   = ((ea - sa + SIZE) % SIZE) + 1;
    per = ((dv == 0) ? 1 : dv) + 1;
    @(negedge clk);
    clear_log();
    cfg_start_addr = AW'(sa);
    cfg_end_addr   = AW'(ea);
    cfg_div        = DIV_BITS'(dv);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    // config must be ignored once the run is under way
    cfg_start_addr = AW'($urandom_range(0, SIZE - 1));
    cfg_end_addr   = AW'($urandom_range(0, SIZE - 1));
    cfg_div        = DIV_BITS'($urandom_range(0, 7));
    check("busy_s1", int'(busy), 1);
    check("rd_en_s1", int'(rd_en), 1);
    check("rd_addr_s1", int'(rd_addr), sa);
`ifdef WAVE_PLAYER_LOOP_EN
    want = 2 * n + 1;
    t = 0;
    while (st_cyc.size() < want && t < 2000) begin
      @(negedge clk);
      t++;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (2 * per + 4) @(negedge clk);
    check("n_strobes", st_cyc.size(), want);
    check("n_done", done_cyc.size(), 0);
    check("n_reads", rd_cnt, want + 1);
    check("busy_after_stop", int'(busy), 0);
`else
    want = n;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("busy_end", int'(busy), 0);
    repeat (per + 4) @(negedge clk);
    check("n_strobes", st_cyc.size(), want);
    check("n_done", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("done_t", done_cyc[0] - s, 3 + (n - 1) * per + 1);
    check("busy_fall_t", fall_cyc - s, 3 + (n - 1) * per + 1);
    check("n_reads", rd_cnt, n);
`endif
    for (int k = 0; k < st_cyc.size() && k < want; k++) begin
      check("strobe_t", st_cyc[k] - s, 3 + k * per);
      check("strobe_v", st_val[k], int'(mem[(sa + (k % n)) % SIZE]));
    end
  endtask

  initial begin
    int sa, len, s, t;
    fill_mem();
    #1;
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_dac_data", int'(dac_data), 0);
    check("rst_strobe", int'(dac_strobe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed windows
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    play(4, 7, 3);
    fill_mem();
    play(98, 1, 1);
    play(5, 5, 0);
    play(0, 2, 2);
    play(99, 99, 1);

    // randomized windows
    for (int r = 0; r < 10; r++) begin
      fill_mem();
      sa  = $urandom_range(0, SIZE - 1);
      len = $urandom_range(1, 6);
      play(sa, (sa + len - 1) % SIZE, $urandom_range(0, 4));
    end

    // abort between 2nd and 3rd strobe
    fill_mem();
    @(negedge clk);
    clear_log();
    cfg_start_addr = AW'(10); cfg_end_addr = AW'(20); cfg_div = DIV_BITS'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (st_cyc.size() < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_strobes", st_cyc.size(), 2);
    check("abort_hold", int'(dac_data), int'(mem[11]));
    check("abort_done", done_cyc.size(), 0);
    check("abort_busy", int'(busy), 0);

    // start and stop together in IDLE
    @(negedge clk);
    clear_log();
    cfg_start_addr = AW'(3); cfg_end_addr = AW'(6); cfg_div = DIV_BITS'(1);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("contend_busy_s1", int'(busy), 0);
    repeat (8) @(negedge clk);
    check("contend_reads", rd_cnt, 0);
    check("contend_strobes", st_cyc.size(), 0);
    check("contend_fall", fall_cyc, -1);

    // asynchronous reset during RUN
    fill_mem();
    mem[30] = 8'hA5;
    @(negedge clk);
    clear_log();
    cfg_start_addr = AW'(30); cfg_end_addr = AW'(40); cfg_div = DIV_BITS'(2);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (st_cyc.size() < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("pre_rst_first_t", (st_cyc.size() > 0) ? st_cyc[0] - s : -1, 3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rd_en", int'(rd_en), 0);
    check("midrst_rd_addr", int'(rd_addr), 0);
    check("midrst_dac_data", int'(dac_data), 0);
    check("midrst_strobe", int'(dac_strobe), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (20) @(negedge clk);
    check("postrst_strobes", st_cyc.size(), 0);
    check("postrst_reads", rd_cnt, 0);
    check("postrst_busy", int'(busy), 0);

    // normal operation resumes with a fresh start
    play(50, 53, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
